atan_arbiter: RTL and testbench

ATAN_ARBITER -- requirements
Module: atan_arbiter

---
 rtl/atan_pkg.sv | 38 +++
 rtl/cordic_arctan.sv | 110 +++++++++++
 rtl/atan_arbiter.sv | 136 +++++++++++++
 tb/tb_atan_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atan_pkg.sv
// Shared types and angle constants for the arctan arbiter and its CORDIC core.
// Angles are Q2.13 at 16 bits (8192 = 1 rad).
package atan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } atan_arb_state_t;

    localparam logic [15:0] ANGLE_PI      = 16'h6488;
    localparam logic [15:0] ANGLE_HALF_PI = 16'h3244;

    // atan(2^-i) in Q2.13, rounded to nearest
    function automatic logic [15:0] atan_step_q13(input int i);
        logic [15:0] v;
        case (i)
            0:       v = 16'd6434;
            1:       v = 16'd3798;
            2:       v = 16'd2007;
            3:       v = 16'd1019;
            4:       v = 16'd511;
            5:       v = 16'd256;
            6:       v = 16'd128;
            7:       v = 16'd64;
            8:       v = 16'd32;
            9:       v = 16'd16;
            10:      v = 16'd8;
            11:      v = 16'd4;
            12:      v = 16'd2;
            13:      v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_arctan.sv
// Iterative vectoring-mode CORDIC arctan: one iteration per cycle, quadrant
// pre-rotation for x < 0, early finish as soon as the residual y reaches zero.
module cordic_arctan
    import atan_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] theta_out
);

    localparam int IW  = WIDTH + 2;
    localparam int CW  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int SHL = (WIDTH >= 16) ? WIDTH - 16 : 0;
    localparam int SHR = (WIDTH < 16) ? 16 - WIDTH : 0;
    localparam logic [CW-1:0] LAST_ITER = CW'(STAGES - 1);

    // Rescale a Q2.13 16-bit constant to the configured angle width
    function automatic logic signed [WIDTH-1:0] scale_q13(input logic [15:0] v);
        logic [WIDTH+15:0] t;
        t = (WIDTH + 16)'(v);
        t = (t << SHL) >> SHR;
        return WIDTH'(t);
    endfunction

    localparam logic signed [WIDTH-1:0] HALF_PI = scale_q13(ANGLE_HALF_PI);

    logic                    busy;
    logic [CW-1:0]           iter;
    logic signed [IW-1:0]    x_r, y_r;
    logic signed [WIDTH-1:0] z_r;

    logic signed [IW-1:0]    x_ext, y_ext, x0, y0;
    logic signed [WIDTH-1:0] z0;
    logic signed [IW-1:0]    x_sh, y_sh, x_nx, y_nx;
    logic signed [WIDTH-1:0] ang, z_nx;

    always_comb begin
        x_ext = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext = {{2{y_in[WIDTH-1]}}, y_in};
        x0    = x_ext;
        y0    = y_ext;
        z0    = '0;
        if (x_in[WIDTH-1]) begin
            if (!y_in[WIDTH-1]) begin
                x0 = y_ext;
                y0 = -x_ext;
                z0 = HALF_PI;
            end else begin
                x0 = -y_ext;
                y0 = x_ext;
                z0 = -HALF_PI;
            end
        end
    end

    always_comb begin
        x_sh = x_r >>> iter;
        y_sh = y_r >>> iter;
        ang  = scale_q13(atan_step_q13(int'(iter)));
        if (y_r[IW-1]) begin
            x_nx = x_r - y_sh;
            y_nx = y_r + x_sh;
            z_nx = z_r - ang;
        end else begin
            x_nx = x_r + y_sh;
            y_nx = y_r - x_sh;
            z_nx = z_r + ang;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            iter      <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            valid_out <= 1'b0;
            theta_out <= '0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                busy <= 1'b1;
                iter <= '0;
                x_r  <= x0;
                y_r  <= y0;
                z_r  <= z0;
            end else if (busy) begin
                if (y_r == '0 || iter == LAST_ITER) begin
                    busy      <= 1'b0;
                    valid_out <= 1'b1;
                    theta_out <= (y_r == '0) ? z_r : z_nx;
                end else begin
                    x_r  <= x_nx;
                    y_r  <= y_nx;
                    z_r  <= z_nx;
                    iter <= iter + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/atan_arbiter.sv
// Round-robin arbiter sharing one cordic_arctan core among NUM_REQ requesters.
// Optional ATAN_ARBITER_STATS_EN adds per-requester accepted-response counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no operation in flight; grant one valid requester
// ST_ISSUE | launch the latched operands into the core (one cycle)
// ST_WAIT  | core iterating; capture theta on its valid_out
// ST_RESP  | result presented until the consumer takes it
module atan_arbiter
    import atan_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int STAGES  = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic signed [WIDTH-1:0]    resp_theta
`ifdef ATAN_ARBITER_STATS_EN
    ,output logic [NUM_REQ*16-1:0]     stat_done
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    atan_arb_state_t state, state_nx;

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         grant_idx;
    logic                    found;
    logic                    take;
    logic [ID_W-1:0]         op_id;
    logic signed [WIDTH-1:0] op_x, op_y;

    logic                    core_valid_in;
    logic                    core_valid_out;
    logic signed [WIDTH-1:0] core_theta;

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        int k;
        found     = 1'b0;
        grant_idx = '0;
        k         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(rr_ptr) + off;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req_valid[ID_W'(k)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
    end

    assign take      = (state == ST_IDLE) && found && !rst;
    assign req_ready = take ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_nx      = state;
        core_valid_in = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            ST_IDLE:  if (take) state_nx = ST_ISSUE;
            ST_ISSUE: begin
                core_valid_in = 1'b1;
                state_nx      = ST_WAIT;
            end
            ST_WAIT:  if (core_valid_out) state_nx = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_x       <= '0;
            op_y       <= '0;
            resp_theta <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                op_id  <= grant_idx;
                op_x   <= req_x[int'(grant_idx)*WIDTH +: WIDTH];
                op_y   <= req_y[int'(grant_idx)*WIDTH +: WIDTH];
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (state == ST_WAIT && core_valid_out) resp_theta <= core_theta;
        end
    end

    assign resp_id = op_id;

    cordic_arctan #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (core_valid_in),
        .x_in      (op_x),
        .y_in      (op_y),
        .valid_out (core_valid_out),
        .theta_out (core_theta)
    );

`ifdef ATAN_ARBITER_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) stat_cnt[k] <= '0;
        end else if (resp_valid && resp_ready && stat_cnt[op_id] != 16'hFFFF) begin
            stat_cnt[op_id] <= stat_cnt[op_id] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_done[g*16 +: 16] = stat_cnt[g];
    end
`endif

endmodule

// File: tb/tb_atan_arbiter.sv
// Directed bench for atan_arbiter: vector table of single operations plus
// sequences for back-pressure, dropped requests, mid-operation reset and fairness.
module tb_atan_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int STAGES  = 13;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_y, req_x;
    logic                     resp_valid, resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic signed [WIDTH-1:0]  resp_theta;
`ifdef ATAN_ARBITER_STATS_EN
    logic [NUM_REQ*16-1:0]    stat_done;
`endif

    always #5 clk = ~clk;

    atan_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_y      (req_y),
        .req_x      (req_x),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_theta (resp_theta)
`ifdef ATAN_ARBITER_STATS_EN
        ,.stat_done (stat_done)
`endif
    );

    typedef struct {
        int k;
        int x;
        int y;
        int theta;
        int tol;
        int lat;   // exact latency required, 0 = only the upper bound
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt[NUM_REQ];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_tol(input string name, input int got, input int exp, input int tol);
        checks++;
        if (got < exp - tol || got > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, got, exp, tol);
        end
    endtask

    task automatic set_op(input int k, input int x, input int y);
        req_x[k*WIDTH +: WIDTH] = WIDTH'(x);
        req_y[k*WIDTH +: WIDTH] = WIDTH'(y);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) acc_cnt[k] = 0;
    endtask

    // Called mid-cycle; returns 1 ns after the grant cycle's negedge
    task automatic wait_grant(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) idx = k;
                check("grant_onehot", int'($onehot(req_ready)), 1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output int lat, output bit ok, output bit rdy_clean);
        lat       = 0;
        ok        = 1'b0;
        rdy_clean = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            lat++;
            if (req_ready != '0) rdy_clean = 1'b0;
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept(input int k);
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
        acc_cnt[k]++;
        check("resp_valid_drop", int'(resp_valid), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int idx, lat;
        bit ok, clean;
        set_op(v.k, v.x, v.y);
        req_valid[v.k] = 1'b1;
        wait_grant(idx, ok);
        check("grant_seen", int'(ok), 1);
        check("grant_idx", idx, v.k);
        @(posedge clk);
        #1;
        req_valid[v.k] = 1'b0;
        wait_resp(lat, ok, clean);
        check("resp_seen", int'(ok), 1);
        check("ready_low_busy", int'(clean), 1);
        if (v.lat != 0) check("latency", lat, v.lat);
        else check_tol("latency", lat, (4 + STAGES + 3) / 2, (STAGES + 3 - 4 + 1) / 2);
        check_tol("theta", int'(resp_theta), v.theta, v.tol);
        check("resp_id", int'(resp_id), v.k);
        accept(v.k);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, lat, th_h, id_h;
        bit ok, clean, stable, rdy0;

        vecs[0] = '{k: 0, x: 1000,  y: 0,     theta: 0,      tol: 0,  lat: 4};
        vecs[1] = '{k: 2, x: 1000,  y: 1000,  theta: 6434,   tol: 8,  lat: 0};
        vecs[2] = '{k: 1, x: 0,     y: 1000,  theta: 12868,  tol: 8,  lat: 0};
        vecs[3] = '{k: 3, x: -1000, y: 0,     theta: 25736,  tol: 16, lat: 0};
        vecs[4] = '{k: 0, x: -1000, y: -1000, theta: -19302, tol: 8,  lat: 0};
        vecs[5] = '{k: 1, x: 1000,  y: -500,  theta: -3798,  tol: 16, lat: 0};
        vecs[6] = '{k: 2, x: 0,     y: 0,     theta: 0,      tol: 0,  lat: 4};
        vecs[7] = '{k: 3, x: 3000,  y: 4000,  theta: 7596,   tol: 16, lat: 0};

        rst        = 1'b1;
        req_valid  = '1;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) acc_cnt[k] = 0;

        // Reset state, with every requester asserting
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_id", int'(resp_id), 0);
        check("rst_resp_theta", int'(resp_theta), 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-pressure: hold in RESP 5 cycles; requester 0 comes and goes, 2 waits
        set_op(3, 0, 1000);
        req_valid[3] = 1'b1;
        wait_grant(idx, ok);
        check("hold_grant", idx, 3);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_resp(lat, ok, clean);
        check("hold_resp_seen", int'(ok), 1);
        th_h   = int'(resp_theta);
        id_h   = int'(resp_id);
        stable = 1'b1;
        rdy0   = 1'b1;
        set_op(0, 1000, 1000);
        set_op(2, 1000, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 0) req_valid = 4'b0101;
            if (c == 3) req_valid[0] = 1'b0;
            @(negedge clk);
            #1;
            if (!resp_valid || int'(resp_theta) != th_h || int'(resp_id) != id_h) stable = 1'b0;
            if (req_ready != '0) rdy0 = 1'b0;
        end
        check("hold_stable", int'(stable), 1);
        check("hold_ready_zero", int'(rdy0), 1);
        check("hold_id", id_h, 3);
        check_tol("hold_theta", th_h, 12868, 8);
        accept(3);
        wait_grant(idx, ok);
        check("dropped_req_skipped", idx, 2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_resp(lat, ok, clean);
        check("after_hold_lat", lat, 4);
        check("after_hold_id", int'(resp_id), 2);
        accept(2);

        // Reset while the core is working; result must be discarded
        set_op(2, 1000, -500);
        req_valid[2] = 1'b1;
        wait_grant(idx, ok);
        check("rst_op_grant", idx, 2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) acc_cnt[k] = 0;
        #1;
        check("midrst_resp_valid", int'(resp_valid), 0);
        clean = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid) clean = 1'b0;
        end
        check("midrst_discarded", int'(clean), 1);

        // Fairness from a fresh pointer: all requesters continuously valid
        for (int k = 0; k < NUM_REQ; k++) set_op(k, 1000, 0);
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int op = 0; op < 5; op++) begin
            wait_grant(idx, ok);
            check("rr_grant", idx, op % NUM_REQ);
            wait_resp(lat, ok, clean);
            check("rr_resp_seen", int'(ok), 1);
            check("rr_resp_id", int'(resp_id), op % NUM_REQ);
            acc_cnt[op % NUM_REQ]++;
        end
        req_valid = '0;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;

        // Two more for requester 1: three accepted in total since reset
        run_vec('{k: 1, x: 500, y: 0, theta: 0, tol: 0, lat: 4});
        run_vec('{k: 1, x: 500, y: 500, theta: 6434, tol: 8, lat: 0});
        check("acc_req1", acc_cnt[1], 3);

`ifdef ATAN_ARBITER_STATS_EN
        for (int k = 0; k < NUM_REQ; k++)
            check($sformatf("stat_done[%0d]", k), int'(stat_done[k*16 +: 16]), acc_cnt[k]);
        do_reset();
        #1;
        for (int k = 0; k < NUM_REQ; k++)
            check($sformatf("stat_rst[%0d]", k), int'(stat_done[k*16 +: 16]), 0);
        for (int i = 0; i < 3; i++) run_vec('{k: 1, x: 1000, y: 0, theta: 0, tol: 0, lat: 4});
        for (int k = 0; k < NUM_REQ; k++)
            check($sformatf("stat_three[%0d]", k), int'(stat_done[k*16 +: 16]), (k == 1) ? 3 : 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
